// File: rtl/icache_lines.sv
// rtl/icache_lines.sv - direct-mapped instruction cache with multi-word lines and burst refill
// Optional feature: define ICACHE_PERF_COUNTERS_EN to build the hit/miss counters.
module icache_lines #(
  parameter int CACHE_SIZE = 1024,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_request,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  read_response,
  output logic [31:0]           read_data,
  input  logic                  invalidate,
  output logic                  memory_read_request,
  input  logic                  memory_read_response,
  output logic [ADDR_WIDTH-1:0] memory_addr,
  input  logic [31:0]           memory_read_data,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);
  localparam int CW    = $clog2(LINE_WORDS);
  localparam int OFF   = CW + 2;
  localparam int LINES = CACHE_SIZE / (4 * LINE_WORDS);
  localparam int IDX   = $clog2(LINES);
  localparam int LA    = ADDR_WIDTH - OFF;

  typedef enum logic {IDLE, REFILL} state_t;
  state_t state, state_next;

  logic [LINES-1:0]     valid;
  logic [LA-IDX-1:0]    tags  [LINES];
  logic [31:0]          words [LINES*LINE_WORDS];

  logic [LA-1:0]        line_q;
  logic [CW-1:0]        beat;
  logic                 abort;

  logic [LA-1:0]        line0, line1, miss_line;
  logic [CW-1:0]        w, w1;
  logic                 straddle, hit0, hit1, hit, miss_start, last_beat;
  logic [31:0]          word_lo, word_hi, lookup_data;
  logic                 unused;

  assign unused = addr[0];

  // Lookup: the addressed line and, for a straddle, the following line
  assign line0    = addr[ADDR_WIDTH-1:OFF];
  assign line1    = line0 + LA'(1);
  assign w        = addr[OFF-1:2];
  assign w1       = w + CW'(1);
  assign straddle = addr[1] && (w == CW'(LINE_WORDS - 1));
  assign hit0     = valid[line0[IDX-1:0]] && (tags[line0[IDX-1:0]] == line0[LA-1:IDX]);
  assign hit1     = valid[line1[IDX-1:0]] && (tags[line1[IDX-1:0]] == line1[LA-1:IDX]);
  assign hit      = hit0 && (!straddle || hit1);
  assign word_lo  = words[{line0[IDX-1:0], w}];
  assign word_hi  = straddle ? words[{line1[IDX-1:0], CW'(0)}] : words[{line0[IDX-1:0], w1}];
  assign lookup_data = addr[1] ? {word_hi[15:0], word_lo[31:16]} : word_lo;

  // The first missing line of the request is refilled first
  assign miss_line  = hit0 ? line1 : line0;
  assign miss_start = (state == IDLE) && read_request && !hit && !invalidate;
  assign last_beat  = (state == REFILL) && memory_read_response && (beat == CW'(LINE_WORDS - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (miss_start) state_next = REFILL;
      REFILL:  if (last_beat)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: zero-wait hit response in IDLE, beat requests in REFILL
  always_comb begin
    read_response       = 1'b0;
    read_data           = '0;
    memory_read_request = 1'b0;
    memory_addr         = '0;
    if (state == IDLE) begin
      if (read_request && hit && !invalidate) begin
        read_response = 1'b1;
        read_data     = lookup_data;
      end
    end else begin
      memory_read_request = 1'b1;
      memory_addr         = {line_q, beat, 2'b00};
    end
  end

  // Refill bookkeeping: latched line, beat counter, invalidate-abort flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_q <= '0;
      beat   <= '0;
      abort  <= 1'b0;
    end else if (miss_start) begin
      line_q <= miss_line;
      beat   <= '0;
      abort  <= 1'b0;
    end else if (state == REFILL) begin
      if (memory_read_response) beat <= beat + CW'(1);
      if (last_beat)       abort <= 1'b0;
      else if (invalidate) abort <= 1'b1;
    end
  end

  // Valid bits: invalidate wins over a completing refill
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  valid <= '0;
    else if (invalidate)         valid <= '0;
    else if (miss_start)         valid[miss_line[IDX-1:0]] <= 1'b0;
    else if (last_beat && !abort) valid[line_q[IDX-1:0]] <= 1'b1;
  end

  // Data and tag arrays are written by refill beats only
  always_ff @(posedge clk) begin
    if (state == REFILL && memory_read_response) begin
      words[{line_q[IDX-1:0], beat}] <= memory_read_data;
      if (beat == CW'(LINE_WORDS - 1)) tags[line_q[IDX-1:0]] <= line_q[LA-1:IDX];
    end
  end

`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] hits, misses;
  logic        refilled;

  // Hits exclude responses that follow a refill of the same request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hits     <= '0;
      misses   <= '0;
      refilled <= 1'b0;
    end else begin
      if (miss_start) misses <= misses + 32'd1;
      if (read_response && !refilled) hits <= hits + 32'd1;
      if (miss_start) refilled <= 1'b1;
      else if (state == IDLE && (read_response || !read_request)) refilled <= 1'b0;
    end
  end

  assign hit_count  = hits;
  assign miss_count = misses;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_lines.sv
// tb/tb_icache_lines.sv - scoreboard bench for icache_lines
module tb_icache_lines;
  localparam int LW = 4;
`ifdef ICACHE_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        read_request = 1'b0;
  logic [31:0] addr = '0;
  logic        read_response;
  logic [31:0] read_data;
  logic        invalidate = 1'b0;
  logic        memory_read_request;
  logic        memory_read_response = 1'b0;
  logic [31:0] memory_addr;
  logic [31:0] memory_read_data = '0;
  logic [31:0] hit_count, miss_count;

  icache_lines dut (
    .clk(clk), .reset(reset), .read_request(read_request), .addr(addr),
    .read_response(read_response), .read_data(read_data), .invalidate(invalidate),
    .memory_read_request(memory_read_request), .memory_read_response(memory_read_response),
    .memory_addr(memory_addr), .memory_read_data(memory_read_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int beats = 0;
  int resp_cnt = 0;
  int inv_at = -1;
  bit inv_now = 1'b0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_maddr[$];
  logic [31:0] mem [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] model_data(input logic [31:0] a);
    logic [31:0] base, lo, hi;
    base = {a[31:2], 2'b00};
    lo = mem_val(base);
    hi = mem_val(base + 32'd4);
    return a[1] ? {hi[15:0], lo[31:16]} : lo;
  endfunction

  task automatic push_line(input logic [31:0] base);
    for (int i = 0; i < LW; i++) exp_maddr.push_back(base + 32'(4 * i));
  endtask

  // One cycle after a falling edge: memory model, invalidate schedule, response monitor
  task automatic cycle_body();
    memory_read_response = 1'b0;
    memory_read_data = '0;
    invalidate = inv_now;
    if (memory_read_request) begin
      if (inv_at == beats) invalidate = 1'b1;
      memory_read_response = 1'b1;
      memory_read_data = mem_val(memory_addr);
      if (exp_maddr.size() == 0) check("extra_beat", memory_addr, 32'hFFFF_FFFF);
      else check("memory_addr", memory_addr, exp_maddr.pop_front());
      beats++;
    end
    #2;
    if (read_response) begin
      resp_cnt++;
      check("resp_in_refill", {31'd0, memory_read_request}, 32'd0);
      if (sb.size() == 0) check("unexpected_resp", 32'(sb.size()), 32'd1);
      else check("read_data", read_data, sb.pop_front());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cycle_body();
    end
  endtask

  task automatic fetch(input logic [31:0] a, input int exp_beats, input string tag);
    int cyc = 0;
    int b0 = beats;
    int r0 = resp_cnt;
    sb.push_back(model_data(a));
    @(negedge clk);
    addr = a;
    read_request = 1'b1;
    cycle_body();
    while (resp_cnt == r0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      cycle_body();
    end
    read_request = 1'b0;
    if (resp_cnt == r0) begin
      check({tag, "_timeout"}, 32'(resp_cnt - r0), 32'd1);
      void'(sb.pop_back());
    end
    check({tag, "_beats"}, 32'(beats - b0), 32'(exp_beats));
    check({tag, "_latency"}, 32'(cyc), 32'(exp_beats + exp_beats / LW));
    if (exp_beats == 0) exp_hits++;
    exp_misses += exp_beats / LW;
  endtask

  initial begin
    int r0;
    int m0;
    // Reset state
    #7;
    check("rst_read_response", {31'd0, read_response}, 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check("rst_mem_req", {31'd0, memory_read_request}, 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Cold aligned miss then same-line hits
    mem[32'h100] = 32'h11; mem[32'h104] = 32'h22; mem[32'h108] = 32'h33; mem[32'h10C] = 32'h44;
    push_line(32'h100);
    fetch(32'h100, 4, "cold_100");
    fetch(32'h104, 0, "hit_104");
    fetch(32'h10C, 0, "hit_10c");

    // New line contents, invalidate in IDLE, unaligned hits
    mem[32'h100] = 32'hAAAA_BBBB; mem[32'h104] = 32'hCCCC_DDDD;
    mem[32'h108] = 32'hEEEE_FFFF; mem[32'h10C] = 32'h1234_5678;
    inv_now = 1'b1; idle(1); inv_now = 1'b0;
    push_line(32'h100);
    fetch(32'h100, 4, "inv_idle_miss");
    fetch(32'h102, 0, "unaligned_102");
    fetch(32'h106, 0, "unaligned_106");

    // Cold straddle: two bursts in line order
    inv_now = 1'b1; idle(1); inv_now = 1'b0;
    m0 = exp_misses;
    push_line(32'h100); push_line(32'h110);
    fetch(32'h10E, 8, "straddle_cold");
    check("straddle_miss_count", miss_count, PERF ? 32'(exp_misses) : 32'd0);
    check("straddle_miss_delta", 32'(exp_misses - m0), 32'd2);
    fetch(32'h10E, 0, "straddle_hit");
    push_line(32'h120);
    fetch(32'h11E, 4, "straddle_half");

    // Straddle wrapping the index from the last line to line 0
    push_line(32'h3F0); push_line(32'h400);
    fetch(32'h3FE, 8, "wrap_straddle");
    fetch(32'h400, 0, "wrap_tag_hit");
    push_line(32'h000);
    fetch(32'h000, 4, "wrap_alias_miss");

    // Aliasing index evicts the earlier line
    push_line(32'h500);
    fetch(32'h500, 4, "alias_500");
    push_line(32'h100);
    fetch(32'h100, 4, "alias_100_again");
    fetch(32'h104, 0, "alias_100_hit");

    // Invalidate mid-burst and on the final beat
    inv_at = beats + 2;
    push_line(32'h200); push_line(32'h200);
    fetch(32'h200, 8, "inv_mid_burst");
    fetch(32'h204, 0, "inv_mid_hit");
    inv_at = beats + 3;
    push_line(32'h240); push_line(32'h240);
    fetch(32'h240, 8, "inv_last_beat");
    fetch(32'h248, 0, "inv_last_hit");
    inv_at = -1;

    // Request dropped mid-refill: burst completes, no response
    push_line(32'h600);
    exp_misses++;
    r0 = resp_cnt;
    @(negedge clk); addr = 32'h600; read_request = 1'b1; cycle_body();
    @(negedge clk); cycle_body(); read_request = 1'b0;
    idle(6);
    check("drop_no_resp", 32'(resp_cnt - r0), 32'd0);
    check("drop_burst_done", 32'(exp_maddr.size()), 32'd0);
    fetch(32'h600, 0, "drop_then_hit");

    // Memory response while IDLE is ignored
    @(negedge clk);
    memory_read_response = 1'b1;
    memory_read_data = 32'hBAD0_BAD0;
    #2;
    check("idle_mem_resp_req", {31'd0, memory_read_request}, 32'd0);
    idle(1);
    fetch(32'h604, 0, "idle_resp_hit");

    check("hit_count", hit_count, PERF ? 32'(exp_hits) : 32'd0);
    check("miss_count", miss_count, PERF ? 32'(exp_misses) : 32'd0);

    // Reset mid-burst
    exp_maddr.push_back(32'h700); exp_maddr.push_back(32'h704);
    @(negedge clk); addr = 32'h700; read_request = 1'b1; cycle_body();
    @(negedge clk); cycle_body();
    @(negedge clk); cycle_body();
    #1 reset = 1'b0;
    #1;
    check("rst_mid_mem_req", {31'd0, memory_read_request}, 32'd0);
    check("rst_mid_read_response", {31'd0, read_response}, 32'd0);
    check("rst_mid_miss_count", miss_count, 32'd0);
    read_request = 1'b0;
    memory_read_response = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_hits = 0;
    exp_misses = 0;
    check("rst_mid_beats", 32'(exp_maddr.size()), 32'd0);
    push_line(32'h600);
    fetch(32'h600, 4, "post_reset_miss");
    check("final_hit_count", hit_count, PERF ? 32'(exp_hits) : 32'd0);
    check("final_miss_count", miss_count, PERF ? 32'(exp_misses) : 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("maddr_empty", 32'(exp_maddr.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
